// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the iterative RV32M/RV64M mul/div unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // For divides the remainder lives in the high half of the accumulator.
  function automatic logic want_high(input logic [2:0] op);
    return op[2] ? op[1] : (op[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pipeline_muldiv_unit_sign_fix.sv
// Final result shaping: optional two's-complement negate and product-half / quotient / remainder select.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic              neg,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  assign prod = neg ? -acc : acc;
  assign quot = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    result = prod[XLEN-1:0];
    if (is_div(op)) begin
      result = want_high(op) ? rem : quot;
    end else if (want_high(op)) begin
      result = prod[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/pipeline_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply, restoring divide,
// one bit per clock on operand magnitudes, sign fixed in a final cycle.
module pipeline_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc, acc_step, acc_init;

  logic              accept, special, div_zero, div_ovf;
  logic              a_neg, b_neg, res_neg;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, fixed_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;

  assign accept = req_i && ready_o && !kill_i;

  assign a_neg = is_signed_a(op_i) && a_i[XLEN-1];
  assign b_neg = is_signed_b(op_i) && b_i[XLEN-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // Remainder takes the dividend's sign; products and quotients take the xor.
  assign res_neg = (is_div(op_i) && want_high(op_i)) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = is_div(op_i) && (b_i == '0);
  assign div_ovf  = is_div(op_i) && is_signed_b(op_i) &&
                    (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    if (div_zero) begin
      special_res = want_high(op_i) ? a_i : '1;
    end else begin
      special_res = want_high(op_i) ? '0 : a_i;
    end
  end

  // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
  assign acc_init = is_div(op_i) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = acc[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};

  always_comb begin
    acc_step = {mul_sum, acc[XLEN-1:1]};
    if (is_div(op_q)) begin
      if (div_diff[XLEN]) begin
        acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
    end
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op     (op_q),
    .neg    (neg_q),
    .acc    (acc),
    .result (fixed_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      result_o <= '0;
      rd_o     <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= op_i;
        rd_q   <= rd_i;
        neg_q  <= res_neg;
        opnd_q <= is_div(op_i) ? b_mag : a_mag;
        acc    <= acc_init;
        cnt    <= '0;
        if (special) begin
          result_o <= special_res;
          rd_o     <= rd_i;
        end
      end else if (state == ST_CALC) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end
      if (state == ST_FIX && !kill_i) begin
        result_o <= fixed_res;
        rd_o     <= rd_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    done_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (accept) state_nxt = special ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (kill_i) state_nxt = ST_IDLE;
        else if (cnt == CNT_W'(XLEN - 1)) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        state_nxt = kill_i ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        ready_o   = 1'b1;
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
        if (accept) state_nxt = special ? ST_DONE : ST_CALC;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipeline_muldiv_unit.sv
// Self-checking bench for pipeline_muldiv_unit (XLEN=32): directed cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_pipeline_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_i = 1'b0;
  logic [2:0]      op_i = 3'b000;
  logic [XLEN-1:0] a_i = '0;
  logic [XLEN-1:0] b_i = '0;
  logic [4:0]      rd_i = '0;
  logic            kill_i = 1'b0;
  logic            ready_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  int nChecks = 0;
  int nPass = 0;

  pipeline_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .rd_i     (rd_i),
    .kill_i   (kill_i),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  always #5 clk = ~clk;

  // Drive and sample 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks = nChecks + 1;
    assert (observed === expected) nPass = nPass + 1;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Reference: architectural RV32M results from wide integer arithmetic.
  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] u;
    longint      s;
    longint      sa;
    longint      sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MUL:    begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
      OP_MULH:   begin s = sa * sb; return s[63:32]; end
      OP_MULHSU: begin s = sa * longint'({32'b0, b}); return s[63:32]; end
      OP_MULHU:  begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        s = sa / sb;
        return s[31:0];
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        s = sa % sb;
        return s[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 0;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    op_i  = op;
    a_i   = a;
    b_i   = b;
    rd_i  = rd;
    req_i = 1'b1;
    checkOutput("ready_at_request", {63'b0, ready_o}, 64'd1);
    tick();
    req_i = 1'b0;
    a_i   = $urandom;
    b_i   = $urandom;
  endtask

  // Counts edges after the accept edge until done_o shows; bounded.
  task automatic waitDone(output int lat, output bit readyLow);
    lat = 0;
    readyLow = 1'b1;
    while (!done_o && lat < 60) begin
      if (ready_o) readyLow = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expected);
    int lat;
    bit readyLow;
    applyStimulus(op, a, b, rd);
    waitDone(lat, readyLow);
    checkOutput({tag, "_result"}, {32'b0, result_o}, {32'b0, expected});
    checkOutput({tag, "_rd"}, {59'b0, rd_o}, {59'b0, rd});
    checkOutput({tag, "_latency"}, 64'(lat), 64'(refLatency(op, a, b)));
    checkOutput({tag, "_ready_low"}, {63'b0, readyLow}, 64'd1);
    tick();
    checkOutput({tag, "_done_pulse"}, {63'b0, done_o}, 64'd0);
  endtask

  initial begin
    logic [31:0] prevResult;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    logic [4:0]  rrd;
    bit          sawDone;
    int          lat;
    bit          readyLow;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_ready", {63'b0, ready_o}, 64'd1);
    checkOutput("reset_done", {63'b0, done_o}, 64'd0);
    checkOutput("reset_result", {32'b0, result_o}, 64'd0);
    checkOutput("reset_rd", {59'b0, rd_o}, 64'd0);

    // Directed arithmetic
    runOp("mul_neg", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB);
    runOp("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    runOp("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    runOp("mulhsu_max", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    runOp("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    runOp("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF);
    runOp("divu", OP_DIVU, 32'd100, 32'd7, 5'd6, 32'd14);
    runOp("remu", OP_REMU, 32'd100, 32'd7, 5'd7, 32'd2);

    // Special cases finish one edge after accept
    runOp("divu_zero", OP_DIVU, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);
    runOp("rem_zero", OP_REM, 32'd5, 32'd0, 5'd9, 32'd5);
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000);
    runOp("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);

    // Kill on the 10th CALC edge
    prevResult = result_o;
    applyStimulus(OP_DIV, 32'd1000, 32'd7, 5'd13);
    for (int i = 0; i < 9; i++) tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    checkOutput("kill_done", {63'b0, done_o}, 64'd0);
    checkOutput("kill_ready", {63'b0, ready_o}, 64'd1);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) sawDone = 1'b1;
      tick();
    end
    checkOutput("kill_no_done", {63'b0, sawDone}, 64'd0);
    checkOutput("kill_result_held", {32'b0, result_o}, {32'b0, prevResult});
    runOp("mul_after_kill", OP_MUL, 32'd3, 32'd4, 5'd14, 32'd12);

    // Request during DONE together with kill is dropped
    applyStimulus(OP_DIVU, 32'd5, 32'd0, 5'd15);
    checkOutput("done_kill_pulse", {63'b0, done_o}, 64'd1);
    op_i = OP_MUL; a_i = 32'd9; b_i = 32'd9; rd_i = 5'd16;
    req_i = 1'b1;
    kill_i = 1'b1;
    tick();
    req_i = 1'b0;
    kill_i = 1'b0;
    checkOutput("done_kill_dropped_done", {63'b0, done_o}, 64'd0);
    checkOutput("done_kill_dropped_ready", {63'b0, ready_o}, 64'd1);

    // Back-to-back accept in the DONE cycle
    applyStimulus(OP_MUL, 32'd5, 32'd6, 5'd17);
    waitDone(lat, readyLow);
    checkOutput("b2b_first_result", {32'b0, result_o}, 64'd30);
    applyStimulus(OP_MUL, 32'd2, 32'd2, 5'd18);
    checkOutput("b2b_busy", {63'b0, ready_o}, 64'd0);
    waitDone(lat, readyLow);
    checkOutput("b2b_latency", 64'(lat), 64'd33);
    checkOutput("b2b_result", {32'b0, result_o}, 64'd4);
    checkOutput("b2b_rd", {59'b0, rd_o}, 64'd18);
    tick();

    // Reset in the middle of CALC
    applyStimulus(OP_MUL, 32'd123, 32'd456, 5'd19);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_ready", {63'b0, ready_o}, 64'd1);
    checkOutput("rst_mid_done", {63'b0, done_o}, 64'd0);
    checkOutput("rst_mid_result", {32'b0, result_o}, 64'd0);
    checkOutput("rst_mid_rd", {59'b0, rd_o}, 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) sawDone = 1'b1;
      tick();
    end
    checkOutput("rst_mid_no_done", {63'b0, sawDone}, 64'd0);

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rrd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      runOp("random", rop, ra, rb, rrd, refResult(rop, ra, rb));
    end

    $display("[TB] directed and random sequences complete");
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
